// File: rtl/control_pipe.sv
// Control-path pipeline registers ID/EX -> EX/MEM -> MEM/WB with
// load-use stall, branch flush and EX-operand forwarding selects.
module control_pipe #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    id_wb,
    input  logic [2:0]    id_m,
    input  logic [3:0]    id_ex,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [AW-1:0] id_rd,
    input  logic          branch_taken,
    output logic          stall,
    output logic [1:0]    ex_alu_op,
    output logic          ex_alu_src,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic          mem_branch,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_dst,
    output logic          wb_reg_write,
    output logic          wb_mem_to_reg,
    output logic [AW-1:0] wb_dst
);

    typedef struct packed {
        logic [1:0]    wb;
        logic [2:0]    m;
        logic [3:0]    ex;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
    } id_ex_t;

    typedef struct packed {
        logic [1:0]    wb;
        logic [2:0]    m;
        logic [AW-1:0] dst;
    } ex_mem_t;

    typedef struct packed {
        logic [1:0]    wb;
        logic [AW-1:0] dst;
    } mem_wb_t;

    id_ex_t        idex;
    ex_mem_t       exmem;
    mem_wb_t       memwb;
    logic [AW-1:0] ex_dst;

    assign ex_dst = idex.ex[3] ? idex.rd : idex.rt;

    // A taken branch already squashes the dependent instruction, so no stall
    assign stall = idex.m[1]
                 && (idex.rt != '0)
                 && ((idex.rt == id_rs) || (idex.rt == id_rt))
                 && !branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            idex  <= '0;
            exmem <= '0;
            memwb <= '0;
        end else begin
            memwb.wb  <= exmem.wb;
            memwb.dst <= exmem.dst;
            if (branch_taken) begin
                idex  <= '0;
                exmem <= '0;
            end else begin
                exmem.wb  <= idex.wb;
                exmem.m   <= idex.m;
                exmem.dst <= ex_dst;
                if (stall) begin
                    idex <= '0;
                end else begin
                    idex.wb <= id_wb;
                    idex.m  <= id_m;
                    idex.ex <= id_ex;
                    idex.rs <= id_rs;
                    idex.rt <= id_rt;
                    idex.rd <= id_rd;
                end
            end
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0) begin
            if (exmem.wb[1] && (exmem.dst == src)) begin
                sel = 2'b10;
            end else if (memwb.wb[1] && (memwb.dst == src)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    assign fwd_a = fwd_sel(idex.rs);
    assign fwd_b = fwd_sel(idex.rt);

    assign ex_alu_op     = idex.ex[2:1];
    assign ex_alu_src    = idex.ex[0];
    assign mem_branch    = exmem.m[2];
    assign mem_read      = exmem.m[1];
    assign mem_write     = exmem.m[0];
    assign mem_dst       = exmem.dst;
    assign wb_reg_write  = memwb.wb[1];
    assign wb_mem_to_reg = memwb.wb[0];
    assign wb_dst        = memwb.dst;

endmodule
